pll_reset_sequencer: RTL and testbench

//  Sequences the 50 MHz->32/100 MHz system PLL: pulses PLL reset, waits for lock, qualifies lock

---
 rtl/pll_seq_pkg.sv | 33 +++
 rtl/pll_reset_sequencer_if.sv | 30 +++
 rtl/bit_sync_2ff.sv | 21 ++
 rtl/pll_reset_sequencer.sv | 123 ++++++++++++
 tb/tb_pll_reset_sequencer.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding, default timing
// parameters and a constant-width helper.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_LOST      = 3'd4,
    ST_FAIL      = 3'd5
  } state_e;

  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT  = 50000;
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_MAX_RETRIES   = 7;
  localparam int DEF_CNT_W         = 8;

  // Number of bits needed to hold values 0..v-1.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Control/status bundle between the PLL reset sequencer and its surroundings.
interface pll_reset_sequencer_if
  import pll_seq_pkg::*;
#(
  parameter int RETRY_W = 3,
  parameter int CNT_W   = DEF_CNT_W
);
  // No valid/ready handshake: all signals are levels sampled on refclk, except
  // sw_restart, which is a single-cycle pulse acted on in the cycle it is seen.
  logic               pll_locked;
  logic               sw_restart;
  logic               pll_rst;
  logic               sys_rst_n;
  logic               ready;
  logic               fail;
  logic [RETRY_W-1:0] retry_cnt;
  logic [CNT_W-1:0]   lock_loss_cnt;
  state_e             state;

  modport master (
    output pll_locked, sw_restart,
    input  pll_rst, sys_rst_n, ready, fail, retry_cnt, lock_loss_cnt, state
  );

  modport slave (
    input  pll_locked, sw_restart,
    output pll_rst, sys_rst_n, ready, fail, retry_cnt, lock_loss_cnt, state
  );

endinterface

// File: rtl/bit_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; output resets to 0.
module bit_sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: pulses PLL reset, waits for and qualifies lock, then
// releases the downstream reset; retries on timeout and re-runs on lock loss.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  pll_reset_sequencer_if.slave  bus
);

  localparam int RETRY_W = clog2(MAX_RETRIES + 1);
  localparam int CYC_MAX_A = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
  localparam int CYC_MAX   = (CYC_MAX_A > RST_CYCLES) ? CYC_MAX_A : RST_CYCLES;
  localparam int CYC_W     = clog2(CYC_MAX + 1);

  localparam logic [CYC_W-1:0]   RST_LAST     = CYC_W'(RST_CYCLES - 1);
  localparam logic [CYC_W-1:0]   TIMEOUT_LAST = CYC_W'(LOCK_TIMEOUT - 1);
  localparam logic [CYC_W-1:0]   STABLE_LAST  = CYC_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

  state_e             state, state_nx;
  logic [CYC_W-1:0]   cyc, cyc_nx;
  logic [RETRY_W-1:0] retry_cnt, retry_nx, retry_inc;
  logic [CNT_W-1:0]   lock_loss_cnt;
  logic               loss_inc;
  logic               locked_s;
  logic               pll_rst, sys_rst_n, ready, fail;

  bit_sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (bus.pll_locked),
    .q     (locked_s)
  );

  always_comb begin
    state_nx  = state;
    cyc_nx    = cyc + CYC_W'(1);
    retry_inc = retry_cnt + RETRY_W'(1);
    retry_nx  = retry_cnt;
    loss_inc  = 1'b0;

    case (state)
      ST_PLL_RST: begin
        if (cyc == RST_LAST) state_nx = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // A lock seen in the timeout cycle still counts as a lock.
        if (locked_s) begin
          state_nx = ST_STABLE;
        end else if (cyc == TIMEOUT_LAST) begin
          retry_nx = retry_inc;
          state_nx = (retry_inc == RETRY_MAX) ? ST_FAIL : ST_PLL_RST;
        end
      end
      ST_STABLE: begin
        if (!locked_s) begin
          state_nx = ST_WAIT_LOCK;
        end else if (cyc == STABLE_LAST) begin
          state_nx = ST_RUN;
          retry_nx = '0;
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_nx = ST_LOST;
          loss_inc = 1'b1;
        end
      end
      ST_LOST:  state_nx = ST_PLL_RST;
      ST_FAIL:  state_nx = ST_FAIL;
      default:  state_nx = ST_PLL_RST;
    endcase

    // Restart overrides everything except the lock-loss count of this cycle.
    if (bus.sw_restart) begin
      state_nx = ST_PLL_RST;
      retry_nx = '0;
    end

    if (bus.sw_restart || (state_nx != state) || (state == ST_RUN) || (state == ST_FAIL))
      cyc_nx = '0;
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_PLL_RST;
      cyc           <= '0;
      retry_cnt     <= '0;
      lock_loss_cnt <= '0;
      pll_rst       <= 1'b1;
      sys_rst_n     <= 1'b0;
      ready         <= 1'b0;
      fail          <= 1'b0;
    end else begin
      state     <= state_nx;
      cyc       <= cyc_nx;
      retry_cnt <= retry_nx;
      if (loss_inc && (lock_loss_cnt != {CNT_W{1'b1}}))
        lock_loss_cnt <= lock_loss_cnt + CNT_W'(1);
      // Outputs decode the next state so they change on the same edge as state.
      pll_rst   <= (state_nx == ST_PLL_RST) || (state_nx == ST_FAIL);
      sys_rst_n <= (state_nx == ST_RUN);
      ready     <= (state_nx == ST_RUN);
      fail      <= (state_nx == ST_FAIL);
    end
  end

  assign bus.pll_rst       = pll_rst;
  assign bus.sys_rst_n     = sys_rst_n;
  assign bus.ready         = ready;
  assign bus.fail          = fail;
  assign bus.retry_cnt     = retry_cnt;
  assign bus.lock_loss_cnt = lock_loss_cnt;
  assign bus.state         = state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer with short timing parameters.
module tb_pll_reset_sequencer;
  import pll_seq_pkg::*;

  localparam int RST_C   = 4;
  localparam int TMO_C   = 100;
  localparam int STB_C   = 16;
  localparam int RETRIES = 3;
  localparam int RETRY_W = 2;
  localparam int CNT_W   = 8;
  localparam int OUT_W   = 3 + 4 + RETRY_W + CNT_W;

  logic refclk;
  logic rst_n;

  pll_reset_sequencer_if #(.RETRY_W(RETRY_W), .CNT_W(CNT_W)) bus ();

  pll_reset_sequencer #(
    .RST_CYCLES    (RST_C),
    .LOCK_TIMEOUT  (TMO_C),
    .STABLE_CYCLES (STB_C),
    .MAX_RETRIES   (RETRIES),
    .CNT_W         (CNT_W)
  ) dut (
    .refclk (refclk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  // clock / reset
  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1 ms");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [OUT_W-1:0] exp_q[$];
  string            name_q[$];
  int               n_checks = 0;
  int               n_errors = 0;

  typedef struct {
    logic   locked;
    logic   restart;
    int     cycles;
    state_e st;
    int     retry;
    int     loss;
  } vec_t;

  vec_t vecs[$];

  // Expected outputs from the state table: pll_rst in PLL_RST/FAIL, reset released only in RUN.
  function automatic logic [OUT_W-1:0] mk(input state_e st, input int retry, input int loss);
    logic pr, sr, rd, fl;
    pr = (st == ST_PLL_RST) || (st == ST_FAIL);
    sr = (st == ST_RUN);
    rd = (st == ST_RUN);
    fl = (st == ST_FAIL);
    return {st, pr, sr, rd, fl, retry[RETRY_W-1:0], loss[CNT_W-1:0]};
  endfunction

  function automatic logic [OUT_W-1:0] actual();
    return {bus.state, bus.pll_rst, bus.sys_rst_n, bus.ready, bus.fail,
            bus.retry_cnt, bus.lock_loss_cnt};
  endfunction

  task automatic sb_push(input string nm, input logic [OUT_W-1:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic sb_check(input logic [OUT_W-1:0] act);
    logic [OUT_W-1:0] e;
    string            nm;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL scoreboard_empty: actual %h with no expected value queued", act);
      return;
    end
    e  = exp_q.pop_front();
    nm = name_q.pop_front();
    if (act !== e) begin
      n_errors++;
      $display("FAIL %s: actual %h required %h (t=%0t)", nm, act, e, $time);
    end
  endtask

  // driver tasks
  task automatic add(input logic l, input logic r, input int c, input state_e st,
                     input int rt, input int ls);
    vec_t v;
    v.locked = l; v.restart = r; v.cycles = c; v.st = st; v.retry = rt; v.loss = ls;
    vecs.push_back(v);
  endtask

  task automatic wait_ready(input logic level, input int bound, output bit ok);
    int n;
    n  = 0;
    ok = 1'b1;
    while (bus.ready !== level && n < bound) begin
      n++;
      @(negedge refclk);
    end
    if (bus.ready !== level) begin
      ok = 1'b0;
      n_checks++;
      n_errors++;
      $display("FAIL wait_ready: ready=%b after %0d cycles, required %b", bus.ready, bound, level);
    end
  endtask

  task automatic measure(input logic level, output int w);
    w = 0;
    while (bus.pll_rst === level && w < 400) begin
      w++;
      @(negedge refclk);
    end
  endtask

  initial begin
    bit ok;
    int w;

    rst_n          = 1'b0;
    bus.pll_locked = 1'b0;
    bus.sw_restart = 1'b0;

    // lock arrives after 10 cycles, loss in RUN, sw_restart, STABLE glitch,
    // sw_restart coincident with lock loss
    add(0, 0,  0, ST_PLL_RST,   0, 0);
    add(0, 0,  3, ST_PLL_RST,   0, 0);
    add(0, 0,  1, ST_WAIT_LOCK, 0, 0);
    add(0, 0, 10, ST_WAIT_LOCK, 0, 0);
    add(1, 0, 18, ST_STABLE,    0, 0);
    add(1, 0,  1, ST_RUN,       0, 0);
    add(0, 0,  1, ST_RUN,       0, 0);
    add(1, 0,  1, ST_RUN,       0, 0);
    add(1, 0,  1, ST_LOST,      0, 1);
    add(1, 0,  1, ST_PLL_RST,   0, 1);
    add(1, 0,  3, ST_PLL_RST,   0, 1);
    add(1, 0,  1, ST_WAIT_LOCK, 0, 1);
    add(1, 0,  1, ST_STABLE,    0, 1);
    add(1, 0, 15, ST_STABLE,    0, 1);
    add(1, 0,  1, ST_RUN,       0, 1);
    add(1, 1,  1, ST_PLL_RST,   0, 1);
    add(1, 0,  4, ST_WAIT_LOCK, 0, 1);
    add(1, 0,  1, ST_STABLE,    0, 1);
    add(1, 0, 10, ST_STABLE,    0, 1);
    add(0, 0,  1, ST_STABLE,    0, 1);
    add(1, 0,  1, ST_STABLE,    0, 1);
    add(1, 0,  1, ST_WAIT_LOCK, 0, 1);
    add(1, 0,  1, ST_STABLE,    0, 1);
    add(1, 0, 15, ST_STABLE,    0, 1);
    add(1, 0,  1, ST_RUN,       0, 1);
    add(0, 0,  1, ST_RUN,       0, 1);
    add(1, 0,  1, ST_RUN,       0, 1);
    add(1, 1,  1, ST_PLL_RST,   0, 2);
    add(1, 0,  4, ST_WAIT_LOCK, 0, 2);

    repeat (3) @(negedge refclk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      bus.pll_locked = vecs[i].locked;
      bus.sw_restart = vecs[i].restart;
      sb_push($sformatf("vec%0d", i), mk(vecs[i].st, vecs[i].retry, vecs[i].loss));
      repeat (vecs[i].cycles) @(negedge refclk);
      sb_check(actual());
    end
    bus.sw_restart = 1'b0;

    // async reset mid-RUN clears everything, including lock_loss_cnt
    wait_ready(1'b1, 100, ok);
    #2 rst_n = 1'b0;
    #1;
    sb_push("async_rst_run", mk(ST_PLL_RST, 0, 0));
    sb_check(actual());

    // async reset mid-STABLE
    @(negedge refclk);
    rst_n = 1'b1;
    repeat (10) @(negedge refclk);
    sb_push("stable_before_rst", mk(ST_STABLE, 0, 0));
    sb_check(actual());
    #2 rst_n = 1'b0;
    #1;
    sb_push("async_rst_stable", mk(ST_PLL_RST, 0, 0));
    sb_check(actual());

    // lock never arrives: three pulses, then FAIL
    bus.pll_locked = 1'b0;
    @(negedge refclk);
    rst_n = 1'b1;
    for (int p = 0; p < RETRIES; p++) begin
      measure(1'b1, w);
      sb_push($sformatf("pll_rst_high%0d", p), OUT_W'(RST_C));
      sb_check(OUT_W'(w));
      measure(1'b0, w);
      sb_push($sformatf("pll_rst_low%0d", p), OUT_W'(TMO_C));
      sb_check(OUT_W'(w));
      if (p < RETRIES - 1) sb_push($sformatf("retry%0d", p), mk(ST_PLL_RST, p + 1, 0));
      else                 sb_push("enter_fail", mk(ST_FAIL, RETRIES, 0));
      sb_check(actual());
    end
    repeat (20) @(negedge refclk);
    sb_push("fail_held", mk(ST_FAIL, RETRIES, 0));
    sb_check(actual());
    bus.sw_restart = 1'b1;
    @(negedge refclk);
    bus.sw_restart = 1'b0;
    sb_push("restart_from_fail", mk(ST_PLL_RST, 0, 0));
    sb_check(actual());

    // 300 lock-loss events: counter must saturate at all-ones
    bus.pll_locked = 1'b1;
    for (int k = 0; k < 300; k++) begin
      wait_ready(1'b1, 100, ok);
      if (!ok) break;
      bus.pll_locked = 1'b0;
      @(negedge refclk);
      bus.pll_locked = 1'b1;
      wait_ready(1'b0, 10, ok);
      if (!ok) break;
    end
    wait_ready(1'b1, 100, ok);
    sb_push("loss_saturated", mk(ST_RUN, 0, 255));
    sb_check(actual());

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
